// File: rtl/counter_display_ctrl.sv
// counter_display_ctrl: run/pause/clear controller for a paced 3-digit BCD counter
// driving three registered seven-segment displays.
module counter_display_ctrl #(
    parameter int TICK_DIV      = 50_000_000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        up_down,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [11:0] count_bcd,
    output logic        running,
    output logic        wrap
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] ZERO  = 7'b1000000;
    localparam logic [6:0] LEAD  = BLANK_LEADING ? BLANK : ZERO;

    state_t state, state_nx;
    logic [1:0] ss_sync, cl_sync, ud_sync, live;
    logic ss_edge, cl_edge, ss_cmd, cl_cmd, tick, step, up, c0, c1, wrap_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [3:0] d0, d1, d2;
    logic [11:0] count_nx;

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = BLANK;
        endcase
    endfunction

    function automatic logic [3:0] nxt(input logic [3:0] d, input logic u);
        nxt = u ? (d == 4'd9 ? 4'd0 : d + 4'd1) : (d == 4'd0 ? 4'd9 : d - 4'd1);
    endfunction

    assign {d2, d1, d0} = count_bcd;
    assign running = state == RUN;
    assign up      = ud_sync[1];
    assign ss_cmd  = ss_sync[1] & ~ss_edge;
    assign cl_cmd  = cl_sync[1] & ~cl_edge;
    assign tick    = state == RUN && presc == LAST;
    assign step    = tick & ~ss_cmd & ~cl_cmd;
    assign c0      = up ? d0 == 4'd9 : d0 == 4'd0;
    assign c1      = c0 && (up ? d1 == 4'd9 : d1 == 4'd0);
    assign wrap_nx = step && c1 && (up ? d2 == 4'd9 : d2 == 4'd0);

    always_comb begin
        state_nx = cl_cmd ? IDLE : ss_cmd ? (state == RUN ? PAUSE : RUN) : state;
        presc_nx = (cl_cmd || state == IDLE) ? '0 : state == RUN ? (tick ? '0 : presc + 1'b1) : presc;
        count_nx = cl_cmd ? 12'h000 :
                   step   ? {c1 ? nxt(d2, up) : d2, c0 ? nxt(d1, up) : d1, nxt(d0, up)} : count_bcd;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            presc     <= '0;
            count_bcd <= 12'h000;
            wrap      <= 1'b0;
            ss_sync   <= 2'b00;
            cl_sync   <= 2'b00;
            ud_sync   <= 2'b00;
            live      <= 2'b00;
            ss_edge   <= 1'b1;
            cl_edge   <= 1'b1;
            hex0      <= ZERO;
            hex1      <= LEAD;
            hex2      <= LEAD;
        end else begin
            state     <= state_nx;
            presc     <= presc_nx;
            count_bcd <= count_nx;
            wrap      <= wrap_nx;
            ss_sync   <= {ss_sync[0], start_stop};
            cl_sync   <= {cl_sync[0], clear};
            ud_sync   <= {ud_sync[0], up_down};
            live      <= {live[0], 1'b1};
            // Edge flops stay high until the synchronizers carry post-reset samples,
            // so an input already held high across reset never yields a command.
            ss_edge   <= live[1] ? ss_sync[1] : 1'b1;
            cl_edge   <= live[1] ? cl_sync[1] : 1'b1;
            hex0      <= seg(d0);
            hex1      <= (BLANK_LEADING && d2 == 4'd0 && d1 == 4'd0) ? BLANK : seg(d1);
            hex2      <= (BLANK_LEADING && d2 == 4'd0) ? BLANK : seg(d2);
        end
    end
endmodule
